// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
// Module   : wb_regfile
// Purpose  : Write-back stage and architectural register file. Selects the
//            write-back value (load data or ALU result), commits it to a
//            NREGS x DW register file whose last entry (X31) reads as zero,
//            and serves two combinational ID-stage read ports with same-cycle
//            write-to-read bypass. Counts committed writes.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            Mem_out             - load data from MEM/WB
//            ALUresult_out       - ALU result from MEM/WB
//            Rd_out              - destination register from MEM/WB
//            WB_out              - [1] RegWrite, [0] MemToReg
//            Ra, Rb / Da, Db     - read addresses / read data
//            wb_data             - selected write-back value
//            wb_we               - effective write enable
//            wb_count            - committed writes since reset (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module wb_regfile #(
  parameter int NREGS = 32,
  parameter int DW    = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] Mem_out,
  input  logic [DW-1:0] ALUresult_out,
  input  logic [4:0]    Rd_out,
  input  logic [1:0]    WB_out,
  input  logic [4:0]    Ra,
  input  logic [4:0]    Rb,
  output logic [DW-1:0] Da,
  output logic [DW-1:0] Db,
  output logic [DW-1:0] wb_data,
  output logic          wb_we,
  output logic [31:0]   wb_count
);

  localparam logic [4:0] c_ZERO_REG = 5'(NREGS - 1);

  logic [DW-1:0] r_regs [0:NREGS-1];
  logic [31:0]   r_wb_count;
  logic [DW-1:0] w_wb_data;
  logic          w_wb_we;

  // Write-back select is always driven; the forwarding unit may use it even
  // when RegWrite is clear.
  assign w_wb_data = WB_out[0] ? Mem_out : ALUresult_out;

  // Reset masks the enable so neither a commit nor a bypass is presented
  // during the reset cycle.
  assign w_wb_we = WB_out[1] & (Rd_out != c_ZERO_REG) & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
      r_wb_count <= '0;
    end else if (w_wb_we) begin
      r_regs[Rd_out] <= w_wb_data;
      r_wb_count     <= r_wb_count + 32'd1;
    end
  end

  // Read port A: zero register first, then bypass, then storage.
  always_comb begin
    Da = r_regs[Ra];
    if (Ra == c_ZERO_REG) begin
      Da = '0;
    end else if (w_wb_we && (Ra == Rd_out)) begin
      Da = w_wb_data;
    end
  end

  // Read port B: identical priority to port A.
  always_comb begin
    Db = r_regs[Rb];
    if (Rb == c_ZERO_REG) begin
      Db = '0;
    end else if (w_wb_we && (Rb == Rd_out)) begin
      Db = w_wb_data;
    end
  end

  assign wb_data  = w_wb_data;
  assign wb_we    = w_wb_we;
  assign wb_count = r_wb_count;

endmodule
`default_nettype wire

// File: doc/wb_regfile.md
# wb_regfile

Write-back stage and architectural register file for the pipelined CPU; the consumer of the MEM/WB pipeline register outputs. Selects the write-back value (memory load data or ALU result), commits it to a 32 x 64-bit register file with X31 hard-wired to zero, and serves the two ID-stage read ports. Same-cycle write-to-read bypass lets an instruction in ID observe a result being written back in the same cycle. A write-back counter is included for performance measurement.

## Interface
- NREGS, 32, number of architectural registers; index 31 is the zero register
- DW, 64, data width
- clk  in  1  rising-edge clock
- rst  in  1  reset; one clock, synchronous and active-high
- Mem_out  in  DW  load data from MEM/WB
- ALUresult_out  in  DW  ALU result from MEM/WB
- Rd_out  in  5  destination register from MEM/WB
- WB_out  in  2  write-back control: bit 1 = RegWrite, bit 0 = MemToReg
- Ra  in  5  ID read address A
- Rb  in  5  ID read address B
- Da  out  DW  read data A
- Db  out  DW  read data B
- wb_data  out  DW  selected write-back value, for the forwarding unit
- wb_we  out  1  effective write enable (RegWrite, Rd != 31, !rst)
- wb_count  out  32  number of committed register writes since reset

## Operation
- wb_data = WB_out[0] ? Mem_out : ALUresult_out. This path is combinational and is always driven, independent of RegWrite.
- wb_we = WB_out[1] & (Rd_out != 31) & !rst. It is combinational.
- Commit: at the rising edge with wb_we = 1, regs[Rd_out] <= wb_data. No other register changes.
- Writes to X31 are discarded. Reads of X31 always return 0.
- Read ports (combinational, evaluated per port):
  - address 31 -> 0
  - else address == Rd_out and wb_we = 1 -> wb_data (bypass)
  - else regs[address]
- Ra == Rb is legal. Both ports return the same value, and both apply the bypass.
- Counter: wb_count increments by 1 at each edge where wb_we = 1. It wraps from 0xFFFFFFFF to 0 with no flag.
- Reset: at the rising edge with rst = 1:
  - all regs clear to 0 and wb_count clears to 0
  - no commit occurs, even if RegWrite is set
  - rst has priority over every write
- Reset mid-pipeline: with rst = 1, wb_we is forced to 0, so no bypass is presented. Da and Db show the pre-reset register contents during that cycle and 0 from the following cycle on.

## Timing
- Write latency: a value presented in cycle N is in the array after edge N. A read in cycle N+1 returns it from storage.
- Bypass: a read in cycle N returns the value being written in cycle N with zero latency. This closes the WB->ID hazard without a stall.
- Read ports and wb_data are purely combinational from their inputs and the current array state. There are no output registers.
- Reset values:
  - regs 0, wb_count 0
  - Da, Db, wb_data, wb_we combinational; wb_we = 0 while rst = 1
- There is no handshake and no back-pressure. The MEM/WB register's enable governs stalls: a held MEM/WB entry with RegWrite set rewrites the same value each cycle, and wb_count counts each repeat. Upstream must clear WB_out[1] on a bubble.

## Test plan
- Reset then read all: assert rst 1 cycle, deassert, sweep Ra/Rb over 0..31 -> every Da/Db = 0, wb_count = 0.
- ALU write-back: WB_out=2'b10, Rd_out=5, ALUresult_out=0x1234 for one cycle -> next cycle Ra=5 gives Da=0x1234, wb_count=1. Repeat with WB_out=2'b11, Mem_out=0xDEADBEEF, Rd_out=6 -> Db(Rb=6)=0xDEADBEEF.
- Bypass: regs[7]=0x11, then WB_out=2'b10, Rd_out=7, ALUresult_out=0x22 with Ra=Rb=7 in the same cycle -> Da=Db=0x22 before the edge, and 0x22 from storage after.
- Zero register: WB_out=2'b10, Rd_out=31, ALUresult_out=0xFF with Ra=31 -> Da=0 in that cycle and the next, wb_we=0, wb_count unchanged.
- No-write and reset collision:
  - WB_out=2'b01, Rd_out=3 -> regs[3] unchanged and wb_count unchanged, while wb_data=Mem_out.
  - rst=1 with WB_out=2'b10, Rd_out=4, Ra=4 -> no bypass (Da = old regs[4]); regs[4]=0 after the edge; wb_count=0.
- Counter wrap: force 0xFFFFFFFF committed writes (or preload via a test hook), then one more write -> wb_count=0.
